exp_range_sel: RTL and testbench
================================

# exp_range_sel

Parametrised, handshaked range-reduction index generator for the exponential datapath. It accepts one unsigned fixed-point operand x and decomposes it as x = k·ln2 + Σ ln(1+2^-j) + residual. It then emits a token stream: one integer token (k), one fractional token per selected j, and a final residual token. The stream feeds the integer/fractional lookup tables downstream. It generalises the single-cycle integer/fractional selector into a multi-step, back-pressurable sequencer.

## Interface
- W, 15: operand/residual width, unsigned Q(W-FRAC).FRAC
- FRAC, 11: fractional bits
- IDX_W, 5: index width; k saturates at 2^IDX_W-1
- LN2_Q, 1419: ln2 constant in operand format
- N_FRA, 11: fractional table entries, j = 1..N_FRA (N_FRA ≤ 2^IDX_W-1)
- LNF_TAB, {1,2,4,8,16,32,63,124,241,457,830}: packed N_FRA×W constants; entry j at bits [j·W-1:(j-1)·W]; defaults are round(ln(1+2^-j)·2^11)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- in_data  in  W  operand x
- out_valid  out  1  token valid
- out_ready  in  1  token accepted when out_valid & out_ready
- out_i  out  IDX_W  index (k, j, or 0 on last token)
- out_int_or_fra  out  1  1 = integer token, 0 = fractional/last token
- out_last  out  1  final token of operand
- out_resid  out  W  residual; valid on last token, 0 otherwise
- out_ovf  out  1  k saturated; sticky per operand, shown on every token

## Operation
- States: IDLE, INT, INT_OUT, FRA, FRA_OUT, LAST.
- IDLE: in_ready=1. On in_valid, register r=in_data, k=0, ovf=0, j=1, then go to INT.
- INT: each cycle:
  - if r ≥ LN2_Q and k < 2^IDX_W-1: r -= LN2_Q, k++;
  - else: ovf = (r ≥ LN2_Q), go to INT_OUT.
- INT_OUT: present (int_or_fra=1, i=k). On handshake, go to FRA, or to LAST if N_FRA=0.
- FRA: one j per cycle.
  - If r ≥ LNF[j]: r -= LNF[j], go to FRA_OUT with i=j.
  - Else: if j=N_FRA go to LAST, otherwise j++.
- FRA_OUT: present (0, j). On handshake: if j=N_FRA go to LAST, otherwise j++ and go to FRA.
- LAST: present (0, 0, last=1, resid=r). On handshake, go to IDLE.
- All comparisons are unsigned. Subtractions never underflow because they are guarded by the compare. r stays W bits.
- Fractional indices are strictly increasing. Each j is used at most once.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, out_i=0, out_int_or_fra=0, out_last=0, out_resid=0, out_ovf=0.
- All outputs are registered. out_valid is high exactly in the *_OUT and LAST states.
- Accept at edge E0. The k subtractions occur at edges E1..Ek. The integer token becomes valid after edge E(k+1).
- Each skipped j costs 1 cycle. Each emitted j costs 1 cycle plus the handshake cycle(s).
- With out_ready held high, a token completes in 1 cycle per output state.
- While out_valid=1 and out_ready=0, all outputs hold stable and no state advances.
- in_ready=0 from E0 until the handshake of the last token. There is no overlap between operands; a new operand is accepted no earlier than the cycle after the last-token handshake.
- If rst_n=0 at any edge, the block returns to the reset values. Any in-flight operand is discarded and no further tokens are emitted for it.
- out_ready while out_valid=0 is ignored.

## Test plan
- x=0: tokens (1,0), then last with resid=0. No fractional tokens. ovf=0.
- x=1419: tokens (1,1), then last with resid=0. The integer token is valid 2 cycles after the accept edge.
- x=2048, out_ready=1: tokens (1,1), (0,2), (0,4), (0,6), (0,7), then last with resid=0.
- IDX_W=4, x=32767: integer token k=15, ovf=1 on all tokens. Fractional phase starts from r=11482.
- x=2048 with out_ready low for 3 cycles on token (0,4): outputs held stable, then the sequence completes identically. in_ready=0 throughout.
- Assert rst_n=0 during FRA for x=2048: the next cycle shows reset values. A following x=1419 produces the correct stream.

Source files
------------

// File: rtl/exp_range_sel.sv
// Range-reduction index generator for the exponential datapath.
// Emits one integer token (k), one token per selected ln(1+2^-j), then the residual.
module exp_range_sel #(
    parameter int W     = 15,
    parameter int FRAC  = 11,
    parameter int IDX_W = 5,
    parameter int LN2_Q = 1419,
    parameter int N_FRA = 11,
    parameter logic [((N_FRA > 0) ? N_FRA : 1)*W-1:0] LNF_TAB = {
        15'd1,   15'd2,   15'd4,   15'd8,   15'd16,  15'd32,
        15'd63,  15'd124, 15'd241, 15'd457, 15'd830
    }
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_i,
    output logic             out_int_or_fra,
    output logic             out_last,
    output logic [W-1:0]     out_resid,
    output logic             out_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_INT_OUT,
        S_FRA,
        S_FRA_OUT,
        S_LAST
    } state_t;

    localparam logic [W-1:0]     LN2    = W'(LN2_Q);
    localparam logic [IDX_W-1:0] KMAX   = '1;
    localparam logic [IDX_W-1:0] JMAX   = IDX_W'(N_FRA);
    localparam bit               NO_FRA = (N_FRA == 0);

    if (FRAC > W || N_FRA > 2**IDX_W - 1) begin : g_bad_cfg
        $error("exp_range_sel: FRAC must fit in W and N_FRA in IDX_W");
    end

    // Table indexed directly by j; slot 0 and slots past N_FRA are never used.
    logic [W-1:0] lnf_tab [2**IDX_W];

    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_tab
        if (g >= 1 && g <= N_FRA) begin : g_used
            assign lnf_tab[g] = LNF_TAB[(g-1)*W +: W];
        end else begin : g_unused
            assign lnf_tab[g] = '0;
        end
    end

    state_t           state;
    logic [W-1:0]     r;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] j;
    logic [W-1:0]     lnf_cur;
    logic             int_go;
    logic             fra_hit;

    assign lnf_cur = lnf_tab[j];
    assign int_go  = (r >= LN2) && (k != KMAX);
    assign fra_hit = (r >= lnf_cur);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            r              <= '0;
            k              <= '0;
            j              <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_i          <= '0;
            out_int_or_fra <= 1'b0;
            out_last       <= 1'b0;
            out_resid      <= '0;
            out_ovf        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        r        <= in_data;
                        k        <= '0;
                        j        <= IDX_W'(1);
                        out_ovf  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (int_go) begin
                        r <= r - LN2;
                        k <= k + IDX_W'(1);
                    end else begin
                        out_ovf        <= (r >= LN2);
                        out_valid      <= 1'b1;
                        out_int_or_fra <= 1'b1;
                        out_i          <= k;
                        state          <= S_INT_OUT;
                    end
                end
                S_INT_OUT: begin
                    if (out_ready) begin
                        out_int_or_fra <= 1'b0;
                        out_i          <= '0;
                        if (NO_FRA) begin
                            out_last  <= 1'b1;
                            out_resid <= r;
                            state     <= S_LAST;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= S_FRA;
                        end
                    end
                end
                S_FRA: begin
                    if (fra_hit) begin
                        r         <= r - lnf_cur;
                        out_valid <= 1'b1;
                        out_i     <= j;
                        state     <= S_FRA_OUT;
                    end else if (j == JMAX) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_resid <= r;
                        out_i     <= '0;
                        state     <= S_LAST;
                    end else begin
                        j <= j + IDX_W'(1);
                    end
                end
                S_FRA_OUT: begin
                    if (out_ready) begin
                        out_i <= '0;
                        if (j == JMAX) begin
                            out_last  <= 1'b1;
                            out_resid <= r;
                            state     <= S_LAST;
                        end else begin
                            out_valid <= 1'b0;
                            j         <= j + IDX_W'(1);
                            state     <= S_FRA;
                        end
                    end
                end
                S_LAST: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_resid <= '0;
                        out_ovf   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_range_sel.sv
// Bench for exp_range_sel: default instance plus an IDX_W=4 instance for saturation.
// Token streams are checked against an arithmetic model of the decomposition.
module tb_exp_range_sel;

    typedef struct packed {
        logic [4:0]  i;
        logic        intf;
        logic        last;
        logic [14:0] resid;
        logic        ovf;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [14:0] in_data = '0;
    logic        out_ready = 1'b0;
    bit          sel = 1'b0;

    logic        a_in_valid, a_in_ready, a_valid, a_intf, a_last, a_ovf;
    logic [4:0]  a_i;
    logic [14:0] a_resid;
    logic        b_in_valid, b_in_ready, b_valid, b_intf, b_last, b_ovf;
    logic [3:0]  b_i;
    logic [14:0] b_resid;

    logic        o_in_ready, o_valid, o_intf, o_last, o_ovf;
    logic [4:0]  o_i;
    logic [14:0] o_resid;

    int n_tests = 0;
    int n_fail  = 0;
    tok_t exp_q[$];
    int lnf [1:11] = '{830, 457, 241, 124, 63, 32, 16, 8, 4, 2, 1};

    always #5 clk = ~clk;

    assign a_in_valid = in_valid & ~sel;
    assign b_in_valid = in_valid & sel;
    assign o_in_ready = sel ? b_in_ready : a_in_ready;
    assign o_valid    = sel ? b_valid : a_valid;
    assign o_intf     = sel ? b_intf : a_intf;
    assign o_last     = sel ? b_last : a_last;
    assign o_ovf      = sel ? b_ovf : a_ovf;
    assign o_i        = sel ? {1'b0, b_i} : a_i;
    assign o_resid    = sel ? b_resid : a_resid;

    exp_range_sel dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_i(a_i),
        .out_int_or_fra(a_intf), .out_last(a_last),
        .out_resid(a_resid), .out_ovf(a_ovf)
    );

    exp_range_sel #(.IDX_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_i(b_i),
        .out_int_or_fra(b_intf), .out_last(b_last),
        .out_resid(b_resid), .out_ovf(b_ovf)
    );

    // x = k*ln2 + sum of selected ln(1+2^-j) + residual, using plain division.
    function automatic void model(input int x, input int kmax);
        int k, r;
        tok_t t;
        exp_q.delete();
        k = x / 1419;
        if (k > kmax) k = kmax;
        r = x - k * 1419;
        t = '0;
        t.i = 5'(k);
        t.intf = 1'b1;
        t.ovf = (r >= 1419);
        exp_q.push_back(t);
        t.intf = 1'b0;
        for (int jj = 1; jj <= 11; jj++) begin
            if (r >= lnf[jj]) begin
                r -= lnf[jj];
                t.i = 5'(jj);
                exp_q.push_back(t);
            end
        end
        t.i = '0;
        t.last = 1'b1;
        t.resid = 15'(r);
        exp_q.push_back(t);
    endfunction

    // mode 0: ready always high, 1: random ready, 2: 3-cycle stall on token (0,4)
    task automatic run_op(input bit which, input int x, input int mode, input string name);
        int   k, nemit, cyc, stalls, first_valid, last_edge;
        bit   done, have_snap;
        tok_t got, e, snap;
        model(x, which ? 15 : 31);
        k = int'(exp_q[0].i);
        nemit = exp_q.size() - 2;
        sel = which;
        stalls = 0;
        first_valid = -1;
        last_edge = 0;
        done = 1'b0;
        have_snap = 1'b0;
        snap = '0;
        @(negedge clk);
        n_tests++;
        if (o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_in_ready: got %b want 1", name, o_in_ready);
        end
        in_valid = 1'b1;
        in_data = 15'(x);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            n_tests++;
            if (o_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_in_ready cyc %0d: got %b want 0", name, cyc, o_in_ready);
            end
            got = {o_i, o_intf, o_last, o_resid, o_ovf};
            if (have_snap) begin
                n_tests++;
                if (o_valid !== 1'b1 || got !== snap) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc %0d: got v=%b %h want v=1 %h",
                             name, cyc, o_valid, got, snap);
                end
                have_snap = 1'b0;
            end
            if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && o_valid && !o_intf && o_i == 5'd4 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else out_ready = 1'b1;
            if (o_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    n_tests++;
                    if (first_valid != k + 1) begin
                        n_fail++;
                        $display("FAIL %s int_latency: got %0d want %0d", name, first_valid, k + 1);
                    end
                end
                if (out_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_token: got %h want none", name, got);
                        done = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL %s token: got i=%0d int=%b last=%b res=%0d ovf=%b want i=%0d int=%b last=%b res=%0d ovf=%b",
                                     name, got.i, got.intf, got.last, got.resid, got.ovf,
                                     e.i, e.intf, e.last, e.resid, e.ovf);
                        end
                        if (e.last) begin
                            done = 1'b1;
                            last_edge = cyc + 1;
                        end
                    end
                end else begin
                    snap = got;
                    have_snap = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: got no last token in %0d cycles want done", name, cyc);
        end else begin
            if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s return_idle: got in_ready=%b valid=%b want 1 0",
                         name, o_in_ready, o_valid);
            end
            if (mode == 0) begin
                n_tests++;
                if (last_edge != k + 14 + nemit) begin
                    n_fail++;
                    $display("FAIL %s total_cycles: got %0d want %0d", name, last_edge, k + 14 + nemit);
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        for (int w = 0; w < 2; w++) begin
            sel = bit'(w);
            #0;
            n_tests++;
            if (o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_i !== 5'd0 || o_intf !== 1'b0 ||
                o_last !== 1'b0 || o_resid !== 15'd0 || o_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: got rdy=%b v=%b i=%0d int=%b last=%b res=%0d ovf=%b want 1 0 0 0 0 0 0",
                         name, w, o_in_ready, o_valid, o_i, o_intf, o_last, o_resid, o_ovf);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(1'b0, 0, 0, "x0");
        run_op(1'b0, 1419, 0, "x1419");
        run_op(1'b0, 2048, 0, "x2048");
        run_op(1'b0, 32767, 0, "xmax");
    endtask

    task automatic test_saturate();
        run_op(1'b1, 32767, 0, "sat15");
        run_op(1'b1, 15 * 1419 + 1418, 0, "sat_edge");
        run_op(1'b1, 15 * 1419 + 1419, 0, "sat_ovf");
    endtask

    task automatic test_stall();
        run_op(1'b0, 2048, 2, "stall_j4");
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 15'd2048;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // k=1: int token handshakes at the 3rd edge, then FRA is active
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("mid_reset");
        repeat (14) begin
            @(negedge clk);
            n_tests++;
            if (a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet: got valid=%b want 0", a_valid);
            end
        end
        out_ready = 1'b0;
        run_op(1'b0, 1419, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(bit'(n % 3 == 2), int'($urandom_range(0, 32767)), n % 2, "rand");
        end
        for (int n = 0; n < 6; n++) begin
            run_op(1'b1, int'($urandom_range(21285, 32767)), 1, "rand_sat");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
